instr_fetch_ctrl: RTL and testbench

Fetch sequencer that drives the combinational instruction memory: owns the fetch PC, issues one word address per cycle, buffers fetched words in a small prefetch FIFO, and presents them to decode over a valid/ready handshake. Handles stall (back-pressure), branch/jump redirect with flush, and the end-of-program boundary of a fixed-size instruction memory. Sits between the instruction memory and the IF/ID stage of the CPU.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/instr_fetch_ctrl_if.sv | 27 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/instr_fetch_ctrl.sv | 80 ++++++++
 tb/tb_instr_fetch_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int WORD_IDX_W = 30;  // byte address >> 2

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    // One prefetch slot: the fetched word and the byte address it came from.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [31:0] pc);
        return pc[31:2];
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, redirect input and decode handshake.
interface instr_fetch_ctrl_if;
    import fetch_pkg::*;

    logic [31:0]        imem_addr_o;
    logic [INSTR_W-1:0] imem_instr_i;
    logic               redirect_i;
    logic [31:0]        redirect_pc_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [INSTR_W-1:0] out_instr_o;
    logic [31:0]        out_pc_o;
    logic               done_o;

    // Environment side: memory model plus decode/branch unit.
    modport master (
        input  imem_addr_o, out_valid_o, out_instr_o, out_pc_o, done_o,
        output imem_instr_i, redirect_i, redirect_pc_i, out_ready_i
    );

    // Fetch controller side.
    modport slave (
        output imem_addr_o, out_valid_o, out_instr_o, out_pc_o, done_o,
        input  imem_instr_i, redirect_i, redirect_pc_i, out_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             din_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    // Head comes straight from storage flops; zero when nothing is held.
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    // Next-state: flush wins, otherwise independent push/pop with wrapping pointers.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_q] = din_i;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, fills the prefetch FIFO from the
// combinational instruction memory, handles redirect and end-of-program.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter int unsigned IMEM_WORDS = 21,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_n,
    instr_fetch_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    function automatic logic pc_in_range(input logic [31:0] pc);
        return {2'b00, word_idx(pc)} < 32'(IMEM_WORDS);
    endfunction

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    fetch_state_e     state_q, state_d;
    logic             in_range, push, pop, full, empty;
    logic [CNT_W-1:0] count, cnt_nxt;
    fetch_entry_t     head, din;

    assign in_range = pc_in_range(fetch_pc_q);
    assign din      = '{pc: fetch_pc_q, instr: bus.imem_instr_i};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_i),
        .din_i   (din),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.imem_addr_o = fetch_pc_q;
    assign bus.out_valid_o = ~empty;
    assign bus.out_instr_o = head.instr;
    assign bus.out_pc_o    = head.pc;
    assign bus.done_o      = (state_q == ST_DONE);

    // Push/pop, next fetch PC and next FSM state; state follows the PC and
    // occupancy that will hold after this edge.
    always_comb begin
        pop        = bus.out_valid_o & bus.out_ready_i & ~bus.redirect_i;
        push       = in_range & ~bus.redirect_i & (~full | pop);
        fetch_pc_d = fetch_pc_q;
        cnt_nxt    = count + CNT_W'(push) - CNT_W'(pop);
        if (bus.redirect_i) begin
            fetch_pc_d = {bus.redirect_pc_i[31:2], 2'b00};
            cnt_nxt    = '0;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (pc_in_range(fetch_pc_d))
            state_d = ST_RUN;
        else if (cnt_nxt != '0)
            state_d = ST_DRAIN;
        else
            state_d = ST_DONE;
    end

    // Fetch PC and FSM state registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            state_q    <= pc_in_range(RESET_PC) ? ST_RUN : ST_DONE;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a 21-word memory model.
module tb_instr_fetch_ctrl;

    logic clk_i;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(.DEPTH(2), .IMEM_WORDS(21), .RESET_PC(32'h0)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory: word k holds 32'h1000_0000 + k; outside range returns filler.
    always_comb begin
        if (bus.imem_addr_o[31:2] < 30'd21)
            bus.imem_instr_i = 32'h1000_0000 + {2'b00, bus.imem_addr_o[31:2]};
        else
            bus.imem_instr_i = 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.out_ready_i   = 1'b1;
        #12;
        chk("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("rst_instr", bus.out_instr_o, 32'd0);
        chk("rst_pc",    bus.out_pc_o, 32'd0);
        chk("rst_addr",  bus.imem_addr_o, 32'd0);
        chk("rst_done",  {31'd0, bus.done_o}, 32'd0);

        // Streaming: one word per cycle, PCs 0..80, then done.
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            step();
            chk("str_valid", {31'd0, bus.out_valid_o}, 32'd1);
            chk("str_pc",    bus.out_pc_o, 32'(4 * (k - 1)));
            chk("str_instr", bus.out_instr_o, 32'h1000_0000 + 32'(k - 1));
            chk("str_done",  {31'd0, bus.done_o}, 32'd0);
        end
        step();
        chk("end_done",  {31'd0, bus.done_o}, 32'd1);
        chk("end_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("end_pc",    bus.out_pc_o, 32'd0);

        // Stall from reset: FIFO fills, fetch PC holds at 8.
        rst_n = 1'b0;
        bus.out_ready_i = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("stall_addr",  bus.imem_addr_o, 32'd8);
        chk("stall_pc",    bus.out_pc_o, 32'd0);
        chk("stall_valid", {31'd0, bus.out_valid_o}, 32'd1);
        bus.out_ready_i = 1'b1;
        step();
        chk("rel_pc4", bus.out_pc_o, 32'd4);
        step();
        chk("rel_pc8", bus.out_pc_o, 32'd8);

        // Redirect to 0x30 while PC 8 is offered: PC 8 dropped, one bubble.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h30;
        step();
        bus.redirect_i = 1'b0;
        chk("rd_bubble", {31'd0, bus.out_valid_o}, 32'd0);
        chk("rd_addr",   bus.imem_addr_o, 32'h30);
        step();
        chk("rd_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("rd_pc48",  bus.out_pc_o, 32'd48);
        step();
        chk("rd_pc52",  bus.out_pc_o, 32'd52);

        // Unaligned target: low bits cleared.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h33;
        step();
        bus.redirect_i = 1'b0;
        chk("ua_bubble", {31'd0, bus.out_valid_o}, 32'd0);
        chk("ua_addr",   bus.imem_addr_o, 32'h30);
        step();
        chk("ua_pc", bus.out_pc_o, 32'd48);

        // Reach DONE via the last word, then redirect out of and back into it.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h50;
        step();
        bus.redirect_i = 1'b0;
        step();
        chk("last_pc",   bus.out_pc_o, 32'h50);
        chk("last_done", {31'd0, bus.done_o}, 32'd0);
        step();
        chk("dn_done",  {31'd0, bus.done_o}, 32'd1);
        chk("dn_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("dn_addr",  bus.imem_addr_o, 32'd84);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0;
        step();
        bus.redirect_i = 1'b0;
        chk("dn0_done",  {31'd0, bus.done_o}, 32'd0);
        chk("dn0_valid", {31'd0, bus.out_valid_o}, 32'd0);
        step();
        chk("dn0_vld", {31'd0, bus.out_valid_o}, 32'd1);
        chk("dn0_pc",  bus.out_pc_o, 32'd0);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        step();
        bus.redirect_i = 1'b0;
        chk("oor_done",  {31'd0, bus.done_o}, 32'd1);
        chk("oor_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("oor_addr",  bus.imem_addr_o, 32'h100);
        step();
        chk("oor_hold",  {31'd0, bus.done_o}, 32'd1);
        chk("oor_vld2",  {31'd0, bus.out_valid_o}, 32'd0);

        // Async reset mid-stream with FIFO full.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0;
        bus.out_ready_i   = 1'b0;
        step();
        bus.redirect_i = 1'b0;
        step();
        step();
        chk("full_pc",   bus.out_pc_o, 32'd0);
        chk("full_addr", bus.imem_addr_o, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("ar_instr", bus.out_instr_o, 32'd0);
        chk("ar_pc",    bus.out_pc_o, 32'd0);
        chk("ar_addr",  bus.imem_addr_o, 32'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        step();
        chk("ar_re_pc0", bus.out_pc_o, 32'd0);
        chk("ar_re_vld", {31'd0, bus.out_valid_o}, 32'd1);
        step();
        chk("ar_re_pc4", bus.out_pc_o, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
